fe_capture_sequencer: RTL and testbench
=======================================

Name: fe_capture_sequencer

Overview:
- Sequences front-end USB capture: arm -> wait for trigger -> programmable delay -> capture enable -> done.
- Sits in the fe_clk domain between the register block, the pattern matcher and fe_capture.
- Drives fe_capture's arm and capture-enable inputs, and drives the external trigger pulse.
- Watches fe_capture's capturing flag to detect the end of capture.

Parameters:
pDELAY_WIDTH, 20, width of trigger delay counter (cycles of fe_clk)
pWIDTH_WIDTH, 17, width of trigger pulse width counter

Ports:
fe_clk  input  1  front-end clock (60 MHz ULPI); only clock
reset_n  input  1  asynchronous active-low reset
I_arm  input  1  arm level, already synchronized to fe_clk; rising edge arms, low disarms
I_trigger_mode  input  1  0 = trigger immediately on arm, 1 = wait for pattern match
I_pattern_match  input  1  single-cycle match pulse from pattern matcher
I_trigger_delay  input  pDELAY_WIDTH  cycles from trigger to capture enable
I_trigger_width  input  pWIDTH_WIDTH  external trigger pulse width in cycles; 0 = no pulse
I_capturing  input  1  fe_capture capturing flag; low = capture finished or blocked
O_arm  output  1  arm level to fe_capture
O_capture_enable  output  1  capture enable to fe_capture
O_trigger  output  1  external trigger pulse
O_armed  output  1  status: sequencer in ARMED or DELAY
O_done  output  1  status: capture completed since last arm
O_state  output  3  current state encoding, for register readback

Behaviour:
- All outputs registered. Reset value of every output is 0; state is IDLE; counters are 0.
- States: IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4. Other encodings go to IDLE next cycle.
- arm_rise = I_arm & !I_arm_q, where I_arm_q is a one-cycle registered copy.
- Disarm rule: I_arm low in any state -> IDLE next cycle. The trigger pulse counter is cleared at the same time. Disarm has priority over all other transitions.
- IDLE: on arm_rise -> ARMED; clear O_done.
- ARMED:
  - Trigger event = (I_trigger_mode==0) | I_pattern_match.
  - With mode 0, the trigger fires in the first ARMED cycle.
  - Pattern-match pulses arriving in IDLE/DELAY/CAPTURE/DONE are ignored.
  - On trigger with I_trigger_delay==0 -> CAPTURE. On trigger with nonzero delay -> DELAY, loading delay_ctr = I_trigger_delay-1.
- DELAY: delay_ctr decrements each cycle; when delay_ctr==0 -> CAPTURE. The delay value is sampled only at the trigger; later changes do not affect the count in flight.
- Timing: with trigger sampled at cycle t, O_capture_enable and O_trigger rise at cycle t+1+D, where D = I_trigger_delay.
- CAPTURE:
  - O_capture_enable=1.
  - A 2-cycle guard counter ignores I_capturing after entry.
  - After the guard, I_capturing==0 -> DONE.
- DONE: O_done=1, O_capture_enable=0. Stays until disarm. A new arm_rise requires I_arm to go low then high, which passes through IDLE.
- O_arm = 1 in ARMED, DELAY, CAPTURE, DONE. fe_capture edge-detects it to clear its capture count.
- O_armed = 1 in ARMED or DELAY.
- O_state = current state encoding.
- Trigger pulse:
  - On entry to CAPTURE, width_ctr loads I_trigger_width.
  - O_trigger = (width_ctr != 0); width_ctr decrements to 0 and saturates there.
  - The pulse runs to completion even if CAPTURE exits to DONE early.
  - Disarm aborts the pulse.
- Saturation: counters never wrap.
  - Max delay (all ones) yields exactly 2^pDELAY_WIDTH-1 cycles of delay.
  - Max width yields exactly 2^pWIDTH_WIDTH-1 high cycles.
- Simultaneous events:
  - arm_rise and I_pattern_match in the same cycle: the match is ignored (sequencer still IDLE).
  - Disarm and trigger in the same cycle: disarm wins.
- Async reset mid-capture: all outputs drop to 0 immediately (not waiting for a clock edge); state becomes IDLE.

Test Plan:
- Mode 0, delay 0, width 4: I_arm rises at cycle 0 -> ARMED at 1, CAPTURE and O_capture_enable=1 at 2, O_trigger high cycles 2-5; I_capturing dropped at cycle 20 -> O_done=1 at 21.
- Mode 1, delay 10, width 0: match pulse at cycle 50 -> O_capture_enable rises at cycle 61; O_trigger stays 0; O_armed high until 60.
- Mode 1, match pulses while IDLE and while in CAPTURE -> no state change; only a match in ARMED triggers.
- Disarm (I_arm low) during DELAY with 100 cycles remaining -> IDLE next cycle; O_arm=0; O_capture_enable never asserts; re-arm restarts from ARMED with O_done=0.
- I_capturing held 0 at CAPTURE entry (FIFO full) -> guard holds CAPTURE 2 cycles, then DONE; a trigger pulse of width 8 still completes all 8 cycles.
- Assert reset_n low mid-CAPTURE between clock edges -> all outputs 0 asynchronously; after release, O_state=0 and the sequencer waits for a fresh arm_rise.

Source files
------------

// File: rtl/fe_capture_sequencer.sv
// Front-end capture sequencer: arm -> trigger -> programmable delay -> capture -> done,
// with an external trigger pulse of programmable width launched on capture entry.
//
// state   | meaning
// IDLE    | disarmed, waiting for a rising edge on I_arm
// ARMED   | armed, waiting for a trigger event
// DELAY   | trigger seen, counting down the programmed delay
// CAPTURE | capture enabled, waiting for fe_capture to stop capturing
// DONE    | capture finished, held until disarm
module fe_capture_sequencer #(
  parameter int pDELAY_WIDTH = 20,
  parameter int pWIDTH_WIDTH = 17
) (
  input  logic                    fe_clk,
  input  logic                    reset_n,
  input  logic                    I_arm,
  input  logic                    I_trigger_mode,
  input  logic                    I_pattern_match,
  input  logic [pDELAY_WIDTH-1:0] I_trigger_delay,
  input  logic [pWIDTH_WIDTH-1:0] I_trigger_width,
  input  logic                    I_capturing,
  output logic                    O_arm,
  output logic                    O_capture_enable,
  output logic                    O_trigger,
  output logic                    O_armed,
  output logic                    O_done,
  output logic [2:0]              O_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic                    arm_in_q;
  logic [pDELAY_WIDTH-1:0] delay_q, delay_d;
  logic [pWIDTH_WIDTH-1:0] width_q, width_d;
  logic [1:0]              guard_q, guard_d;
  logic                    done_q, done_d;
  logic                    arm_out_q, armed_q, cen_q, trig_q;
  logic                    arm_rise;

  assign arm_rise = I_arm & ~arm_in_q;

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    guard_d = guard_q;
    done_d  = done_q;
    // The trigger pulse drains on its own, independent of the state it was launched in.
    width_d = (width_q != '0) ? width_q - pWIDTH_WIDTH'(1) : '0;

    if (!I_arm) begin
      state_d = ST_IDLE;
      delay_d = '0;
      guard_d = '0;
      width_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_rise) begin
            state_d = ST_ARMED;
            done_d  = 1'b0;
          end
        end
        ST_ARMED: begin
          if (!I_trigger_mode || I_pattern_match) begin
            if (I_trigger_delay == '0) begin
              state_d = ST_CAPTURE;
              width_d = I_trigger_width;
              guard_d = 2'd2;
            end else begin
              state_d = ST_DELAY;
              delay_d = I_trigger_delay - pDELAY_WIDTH'(1);
            end
          end
        end
        ST_DELAY: begin
          if (delay_q == '0) begin
            state_d = ST_CAPTURE;
            width_d = I_trigger_width;
            guard_d = 2'd2;
          end else begin
            delay_d = delay_q - pDELAY_WIDTH'(1);
          end
        end
        ST_CAPTURE: begin
          // fe_capture needs a couple of cycles before its capturing flag is meaningful.
          if (guard_q != 2'd0) begin
            guard_d = guard_q - 2'd1;
          end else if (!I_capturing) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      arm_in_q  <= 1'b0;
      delay_q   <= '0;
      width_q   <= '0;
      guard_q   <= 2'd0;
      done_q    <= 1'b0;
      arm_out_q <= 1'b0;
      armed_q   <= 1'b0;
      cen_q     <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_in_q  <= I_arm;
      delay_q   <= delay_d;
      width_q   <= width_d;
      guard_q   <= guard_d;
      done_q    <= done_d;
      arm_out_q <= (state_d != ST_IDLE);
      armed_q   <= (state_d == ST_ARMED) || (state_d == ST_DELAY);
      cen_q     <= (state_d == ST_CAPTURE);
      trig_q    <= (width_d != '0);
    end
  end

  assign O_arm            = arm_out_q;
  assign O_capture_enable = cen_q;
  assign O_trigger        = trig_q;
  assign O_armed          = armed_q;
  assign O_done           = done_q;
  assign O_state          = state_q;

endmodule

// File: tb/tb_fe_capture_sequencer.sv
// Directed self-checking bench for fe_capture_sequencer; expected values are hand-derived.
module tb_fe_capture_sequencer;

  localparam int DW = 20;
  localparam int WW = 17;

  logic          fe_clk = 1'b0;
  logic          reset_n;
  logic          I_arm;
  logic          I_trigger_mode;
  logic          I_pattern_match;
  logic [DW-1:0] I_trigger_delay;
  logic [WW-1:0] I_trigger_width;
  logic          I_capturing;
  logic          O_arm, O_capture_enable, O_trigger, O_armed, O_done;
  logic [2:0]    O_state;

  int errors = 0;
  int checks = 0;
  int cnt;

  fe_capture_sequencer #(.pDELAY_WIDTH(DW), .pWIDTH_WIDTH(WW)) dut (
    .fe_clk           (fe_clk),
    .reset_n          (reset_n),
    .I_arm            (I_arm),
    .I_trigger_mode   (I_trigger_mode),
    .I_pattern_match  (I_pattern_match),
    .I_trigger_delay  (I_trigger_delay),
    .I_trigger_width  (I_trigger_width),
    .I_capturing      (I_capturing),
    .O_arm            (O_arm),
    .O_capture_enable (O_capture_enable),
    .O_trigger        (O_trigger),
    .O_armed          (O_armed),
    .O_done           (O_done),
    .O_state          (O_state)
  );

  always #5 fe_clk = ~fe_clk;

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic arm,
                          input logic armed, input logic cen, input logic done);
    chk({tag, ".state"}, 32'(O_state), 32'(st));
    chk({tag, ".arm"},   32'(O_arm), 32'(arm));
    chk({tag, ".armed"}, 32'(O_armed), 32'(armed));
    chk({tag, ".cen"},   32'(O_capture_enable), 32'(cen));
    chk({tag, ".done"},  32'(O_done), 32'(done));
  endtask

  initial begin
    reset_n         = 1'b0;
    I_arm           = 1'b0;
    I_trigger_mode  = 1'b0;
    I_pattern_match = 1'b0;
    I_trigger_delay = '0;
    I_trigger_width = '0;
    I_capturing     = 1'b1;
    tick();
    tick();
    chk_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.trig", 32'(O_trigger), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", 32'(O_state), 32'd0);

    // Mode 0, delay 0, width 4
    I_trigger_width = 17'd4;
    I_arm = 1'b1;
    tick();
    chk_outs("m0.armed", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_outs("m0.capture", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("m0.trig_rise", 32'(O_trigger), 32'd1);
    cnt = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (O_trigger) cnt++;
    end
    chk("m0.trig_width", 32'(cnt), 32'd4);
    chk("m0.still_capture", 32'(O_state), 32'd3);
    I_capturing = 1'b0;
    tick();
    chk_outs("m0.done", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    I_capturing = 1'b1;
    tick();
    chk("m0.done_hold", 32'(O_state), 32'd4);

    // Disarm from DONE; done status persists until the next arm
    I_arm = 1'b0;
    tick();
    chk_outs("disarm_done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Mode 1, delay 10, width 0; matches outside ARMED are ignored
    I_trigger_mode  = 1'b1;
    I_trigger_delay = 20'd10;
    I_trigger_width = 17'd0;
    I_pattern_match = 1'b1;
    tick();
    I_pattern_match = 1'b0;
    chk("m1.match_in_idle", 32'(O_state), 32'd0);
    I_arm = 1'b1;
    I_pattern_match = 1'b1;
    tick();
    I_pattern_match = 1'b0;
    chk_outs("m1.arm_with_match", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("m1.wait_match", 32'(O_state), 32'd1);
    I_pattern_match = 1'b1;
    tick();
    I_pattern_match = 1'b0;
    chk_outs("m1.delay", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (O_state == 3'd2 && O_armed && !O_capture_enable) cnt++;
    end
    chk("m1.delay_cycles", 32'(cnt), 32'd9);
    tick();
    chk_outs("m1.capture", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("m1.no_trig", 32'(O_trigger), 32'd0);
    tick();
    tick();
    I_pattern_match = 1'b1;
    tick();
    I_pattern_match = 1'b0;
    chk("m1.match_in_capture", 32'(O_state), 32'd3);
    I_capturing = 1'b0;
    tick();
    chk("m1.done", 32'(O_state), 32'd4);
    I_capturing = 1'b1;

    // Disarm during DELAY with 100 cycles remaining
    I_arm = 1'b0;
    I_trigger_mode  = 1'b0;
    I_trigger_delay = 20'd200;
    tick();
    I_arm = 1'b1;
    tick();
    chk("dis.armed", 32'(O_state), 32'd1);
    chk("dis.done_cleared", 32'(O_done), 32'd0);
    tick();
    cnt = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (O_capture_enable) cnt++;
    end
    chk("dis.in_delay", 32'(O_state), 32'd2);
    I_arm = 1'b0;
    tick();
    if (O_capture_enable) cnt++;
    chk_outs("dis.idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis.cen_never", 32'(cnt), 32'd0);

    // Re-arm, delay 3; changing the delay input mid-count has no effect
    I_trigger_delay = 20'd3;
    I_arm = 1'b1;
    tick();
    chk_outs("rearm", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    I_trigger_delay = 20'd50;
    chk("d3.delay", 32'(O_state), 32'd2);
    tick();
    tick();
    chk("d3.still_delay", 32'(O_state), 32'd2);
    tick();
    chk("d3.capture", 32'(O_capture_enable), 32'd1);

    // Capturing low at entry: guard holds CAPTURE, pulse of 8 completes in DONE
    I_arm = 1'b0;
    tick();
    I_trigger_delay = 20'd0;
    I_trigger_width = 17'd8;
    I_capturing = 1'b0;
    I_arm = 1'b1;
    tick();
    tick();
    chk("g.capture_entry", 32'(O_state), 32'd3);
    cnt = O_trigger ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (O_trigger) cnt++;
      if (i < 2) chk("g.guard_hold", 32'(O_state), 32'd3);
      if (i == 2) chk("g.done", 32'(O_state), 32'd4);
    end
    chk("g.trig_width", 32'(cnt), 32'd8);
    chk("g.trig_end", 32'(O_trigger), 32'd0);
    I_capturing = 1'b1;

    // Async reset mid-CAPTURE
    I_arm = 1'b0;
    tick();
    I_trigger_width = 17'd100;
    I_arm = 1'b1;
    tick();
    tick();
    chk("ar.capture", 32'(O_state), 32'd3);
    chk("ar.trig", 32'(O_trigger), 32'd1);
    #2;
    reset_n = 1'b0;
    I_arm = 1'b0;
    #1;
    chk_outs("ar.async", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ar.trig_low", 32'(O_trigger), 32'd0);
    tick();
    #2;
    reset_n = 1'b1;
    tick();
    tick();
    chk("ar.idle_wait", 32'(O_state), 32'd0);
    I_arm = 1'b1;
    tick();
    chk("ar.fresh_arm", 32'(O_state), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
